// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, maskable, prioritised interrupt sequencer with assert/ack/eoi handshake.
// Optional INTR_CTRL_ROUND_ROBIN_EN rotates priority from the last acknowledged code.
module interrupt_controller #(
  parameter logic [15:0] ENABLE_RESET = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] requests,
  input  logic        enable_we,
  input  logic [15:0] enable_wdata,
  output logic [15:0] enables,
  output logic [15:0] pending,
  output logic        irq,
  output logic [3:0]  irq_code,
  input  logic        ack,
  input  logic        eoi,
  output logic        in_service
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
  state_t state, state_next;
  logic [15:0] req_prev, rise, cand, clr;
  logic [3:0] winner;
  logic take;
  assign rise = requests & ~req_prev;
  assign cand = pending & enables;
  assign take = state == ASSERT && ack;
  assign clr = take ? 16'h1 << irq_code : '0;
  assign irq = state == ASSERT;
  assign in_service = state == SERVICE;
`ifdef INTR_CTRL_ROUND_ROBIN_EN
  logic [3:0] last_grant, idx;
  logic found;
  always_comb begin
    winner = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = last_grant + 4'(k + 1);
      if (!found && cand[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) last_grant <= 4'hF;
    else if (take) last_grant <= irq_code;
`else
  always_comb begin
    winner = '0;
    for (int i = 15; i >= 0; i--)
      if (cand[i]) winner = 4'(i);
  end
`endif
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = cand != '0 ? ASSERT : IDLE;
      ASSERT:  state_next = ack ? SERVICE : ASSERT;
      SERVICE: state_next = eoi ? IDLE : SERVICE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      irq_code <= '0;
      pending  <= '0;
      enables  <= ENABLE_RESET;
      req_prev <= '0;
    end else begin
      state    <= state_next;
      req_prev <= requests;
      // a fresh edge on the bit being acknowledged must survive the clear
      pending  <= (pending & ~clr) | rise;
      if (enable_we) enables <= enable_wdata;
      if (state == IDLE && cand != '0) irq_code <= winner;
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vector table plus a hand-written arbitration-order sequence.
module tb_interrupt_controller;
  logic clk = 0, rst, enable_we, ack, eoi, irq, in_service;
  logic [15:0] requests, enable_wdata, enables, pending;
  logic [3:0] irq_code;
  int checks = 0, errors = 0;
  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        we;
    logic [15:0] wdata;
    logic        ack;
    logic        eoi;
    logic        x_irq;
    logic [3:0]  x_code;
    logic        x_ins;
    logic [15:0] x_pend;
    logic [15:0] x_en;
  } vec_t;
  vec_t tbl[35];
  interrupt_controller dut (
    .clk(clk), .rst(rst), .requests(requests), .enable_we(enable_we),
    .enable_wdata(enable_wdata), .enables(enables), .pending(pending),
    .irq(irq), .irq_code(irq_code), .ack(ack), .eoi(eoi), .in_service(in_service)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic [15:0] q, logic w, logic [15:0] d, logic a, logic e,
                             logic xi, logic [3:0] xc, logic xs, logic [15:0] xp, logic [15:0] xe);
    vec_t t;
    t.rst = r; t.req = q; t.we = w; t.wdata = d; t.ack = a; t.eoi = e;
    t.x_irq = xi; t.x_code = xc; t.x_ins = xs; t.x_pend = xp; t.x_en = xe;
    return t;
  endfunction
  task automatic drive(logic r, logic [15:0] q, logic w, logic [15:0] d, logic a, logic e);
    rst = r; requests = q; enable_we = w; enable_wdata = d; ack = a; eoi = e;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] exp_code;
    //          rst req      we wdata    ack eoi  irq code ins pend     en
    tbl[0]  = v(1, 16'h0008, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 16'hFFFF);
    tbl[1]  = v(1, 16'h0008, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 16'hFFFF);
    tbl[2]  = v(0, 16'h0008, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0008, 16'hFFFF);
    tbl[3]  = v(0, 16'h0008, 0, 16'h0000, 0, 0,   1, 3, 0, 16'h0008, 16'hFFFF);
    tbl[4]  = v(0, 16'h0008, 0, 16'h0000, 1, 0,   0, 3, 1, 16'h0000, 16'hFFFF);
    tbl[5]  = v(0, 16'h0008, 0, 16'h0000, 0, 1,   0, 3, 0, 16'h0000, 16'hFFFF);
    tbl[6]  = v(0, 16'h0000, 0, 16'h0000, 0, 0,   0, 3, 0, 16'h0000, 16'hFFFF);
    tbl[7]  = v(0, 16'h0006, 0, 16'h0000, 0, 0,   0, 3, 0, 16'h0006, 16'hFFFF);
    tbl[8]  = v(0, 16'h0006, 0, 16'h0000, 0, 0,   1, 1, 0, 16'h0006, 16'hFFFF);
    tbl[9]  = v(0, 16'h0006, 0, 16'h0000, 1, 0,   0, 1, 1, 16'h0004, 16'hFFFF);
    tbl[10] = v(0, 16'h0006, 0, 16'h0000, 0, 1,   0, 1, 0, 16'h0004, 16'hFFFF);
    tbl[11] = v(0, 16'h0006, 0, 16'h0000, 0, 0,   1, 2, 0, 16'h0004, 16'hFFFF);
    tbl[12] = v(0, 16'h0006, 0, 16'h0000, 1, 0,   0, 2, 1, 16'h0000, 16'hFFFF);
    tbl[13] = v(0, 16'h0000, 0, 16'h0000, 0, 1,   0, 2, 0, 16'h0000, 16'hFFFF);
    tbl[14] = v(0, 16'h0000, 1, 16'hFFFE, 0, 0,   0, 2, 0, 16'h0000, 16'hFFFE);
    tbl[15] = v(0, 16'h0001, 0, 16'h0000, 0, 0,   0, 2, 0, 16'h0001, 16'hFFFE);
    tbl[16] = v(0, 16'h0001, 0, 16'h0000, 0, 0,   0, 2, 0, 16'h0001, 16'hFFFE);
    tbl[17] = v(0, 16'h0001, 1, 16'hFFFF, 0, 0,   0, 2, 0, 16'h0001, 16'hFFFF);
    tbl[18] = v(0, 16'h0001, 0, 16'h0000, 0, 0,   1, 0, 0, 16'h0001, 16'hFFFF);
    tbl[19] = v(0, 16'h0001, 0, 16'h0000, 0, 1,   1, 0, 0, 16'h0001, 16'hFFFF);
    tbl[20] = v(0, 16'h0000, 0, 16'h0000, 1, 1,   0, 0, 1, 16'h0000, 16'hFFFF);
    tbl[21] = v(0, 16'h0000, 0, 16'h0000, 0, 1,   0, 0, 0, 16'h0000, 16'hFFFF);
    tbl[22] = v(0, 16'h0002, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0002, 16'hFFFF);
    tbl[23] = v(0, 16'h0000, 0, 16'h0000, 0, 0,   1, 1, 0, 16'h0002, 16'hFFFF);
    tbl[24] = v(0, 16'h0002, 0, 16'h0000, 1, 0,   0, 1, 1, 16'h0002, 16'hFFFF);
    tbl[25] = v(0, 16'h0002, 0, 16'h0000, 0, 1,   0, 1, 0, 16'h0002, 16'hFFFF);
    tbl[26] = v(0, 16'h0002, 0, 16'h0000, 0, 0,   1, 1, 0, 16'h0002, 16'hFFFF);
    tbl[27] = v(0, 16'h0000, 0, 16'h0000, 1, 0,   0, 1, 1, 16'h0000, 16'hFFFF);
    tbl[28] = v(0, 16'h0000, 0, 16'h0000, 0, 1,   0, 1, 0, 16'h0000, 16'hFFFF);
    tbl[29] = v(0, 16'h0000, 0, 16'h0000, 1, 0,   0, 1, 0, 16'h0000, 16'hFFFF);
    tbl[30] = v(0, 16'h0010, 0, 16'h0000, 0, 0,   0, 1, 0, 16'h0010, 16'hFFFF);
    tbl[31] = v(0, 16'h0010, 0, 16'h0000, 0, 0,   1, 4, 0, 16'h0010, 16'hFFFF);
    tbl[32] = v(0, 16'h0010, 0, 16'h0000, 1, 0,   0, 4, 1, 16'h0000, 16'hFFFF);
    tbl[33] = v(1, 16'h0020, 1, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 16'hFFFF);
    tbl[34] = v(0, 16'h0000, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 16'hFFFF);
    @(negedge clk);
    for (int i = 0; i < 35; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].wdata, tbl[i].ack, tbl[i].eoi);
      checks++;
      if ({irq, irq_code, in_service, pending, enables} !==
          {tbl[i].x_irq, tbl[i].x_code, tbl[i].x_ins, tbl[i].x_pend, tbl[i].x_en}) begin
        errors++;
        $display("FAIL vec%0d: got irq=%b code=%0d ins=%b pend=%h en=%h, want irq=%b code=%0d ins=%b pend=%h en=%h",
                 i, irq, irq_code, in_service, pending, enables,
                 tbl[i].x_irq, tbl[i].x_code, tbl[i].x_ins, tbl[i].x_pend, tbl[i].x_en);
      end
    end
    // lines 0 and 1 re-raised while in service: order shows fixed vs rotating priority
    drive(0, 16'h0003, 0, 0, 0, 0);
    drive(0, 16'h0000, 0, 0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      if (g > 0) begin
        drive(0, 16'h0000, 0, 0, 1, 0);
        drive(0, 16'h0003, 0, 0, 0, 0);
        drive(0, 16'h0000, 0, 0, 0, 1);
        drive(0, 16'h0000, 0, 0, 0, 0);
      end
`ifdef INTR_CTRL_ROUND_ROBIN_EN
      exp_code = 4'(g % 2);
`else
      exp_code = 4'd0;
`endif
      checks++;
      if (irq !== 1'b1 || irq_code !== exp_code) begin
        errors++;
        $display("FAIL grant%0d: got irq=%b code=%0d, want irq=1 code=%0d", g, irq, irq_code, exp_code);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences the 16-line interrupt request vector produced by the interrupt splitter and presents at most one interrupt at a time to the CPU.
- Detects rising edges, latches them as pending, applies a per-line enable mask, and arbitrates by priority.
- Runs an assert/acknowledge/end-of-interrupt handshake with the CPU.
- Sits between the splitter and the CPU's interrupt input.

Parameters:
- ENABLE_RESET, 16'hFFFF, reset value of the per-line enable register (1 = line may interrupt).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- requests  input  16  request lines from splitter, bit i = interrupt code i
- enable_we  input  1  write strobe for enable register
- enable_wdata  input  16  new enable value, taken when enable_we=1
- enables  output  16  current enable register
- pending  output  16  current pending register
- irq  output  1  interrupt request to CPU
- irq_code  output  4  code of presented interrupt; valid while irq=1 or in_service=1
- ack  input  1  CPU accepts presented interrupt
- eoi  input  1  CPU finished servicing
- in_service  output  1  CPU is inside a handler

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE; irq=0; irq_code=0; in_service=0; pending=0; enables=ENABLE_RESET.
  - req_prev=0, so a line held high through reset yields an edge on the first cycle after reset.
  - Reset mid-handshake aborts it; no interrupt is retained.
- Edge detection:
  - rise = requests & ~req_prev; req_prev <= requests every cycle.
  - pending[i] <= 1 on rise[i], regardless of enables.
  - Masked edges stay pending and fire once enabled.
- Pending clear: pending[irq_code] <= 0 on an accepted ack. If rise on the same bit in the same cycle, the set wins and the bit stays 1.
- Enable write: enables <= enable_wdata when enable_we=1. Takes effect for arbitration in the next cycle. Does not retract an interrupt already in ASSERT.
- Arbitration: candidates = pending & enables. Fixed priority, lowest index wins (code 0 = PS/2 highest).
- FSM:
  - IDLE: if candidates != 0 -> ASSERT; irq<=1, irq_code<=winner.
  - ASSERT: irq held 1, irq_code frozen. On ack=1 -> SERVICE; irq<=0, in_service<=1, pending bit cleared.
  - SERVICE: in_service=1, irq_code held. On eoi=1 -> IDLE; in_service<=0.
  - ack outside ASSERT is ignored; eoi outside SERVICE is ignored. ack and eoi asserted together in ASSERT: ack taken, eoi ignored.
- Latency:
  - requests rise sampled at edge N -> pending set at N -> irq=1 after edge N+1.
  - From IDLE with a candidate, irq is asserted after one edge.
  - After eoi, a next candidate is asserted 2 edges later (IDLE for one cycle); no back-to-back without IDLE.
- No nesting: new edges during ASSERT/SERVICE only set pending.

Optional Feature:
- Macro INTR_CTRL_ROUND_ROBIN_EN.
- Defined:
  - A 4-bit last_grant register (reset 4'hF) is updated to irq_code on accepted ack.
  - Arbitration searches candidates starting at last_grant+1 (mod 16), wrapping around; the first set bit wins.
  - After reset the order equals fixed priority.
- Undefined: fixed lowest-index priority; no last_grant register.

Test Plan:
- Reset with requests=16'h0008 held -> after rst release: pending[3]=1 after edge 1, irq=1 with irq_code=3 after edge 2; ack -> irq=0, in_service=1, pending=0; eoi -> in_service=0.
- requests 0x0004 and 0x0002 rising together -> irq_code=1 first. After ack+eoi, irq_code=2. Round-robin build gives the same order from reset.
- enable_wdata=16'hFFFE written, then requests[0] rises -> pending[0]=1, irq stays 0. Write 16'hFFFF -> irq=1, irq_code=0 one edge after the write is visible.
- In ASSERT for code 1, requests[1] toggles 0->1 in the same cycle as ack -> pending[1] remains 1. After eoi, code 1 is re-presented.
- Stray ack in IDLE and eoi in ASSERT -> no state change, irq/in_service unchanged. rst=1 during SERVICE -> all outputs at reset values on the next cycle.
- With INTR_CTRL_ROUND_ROBIN_EN, lines 0 and 1 toggled continuously -> grants alternate 0,1,0,1. Without the macro, line 0 is granted every time.
